// File: rtl/pipe_field.sv
// Scrolling pipe obstacles for the flappy-bird playfield: LFSR hole placement,
// selectable scroll speed, exact pipe spacing, pass detection and a saturating score.
module pipe_field #(
  parameter int unsigned N_PIPES  = 3,
  parameter int unsigned X_SIZE   = 40,
  parameter int unsigned Y_HOLE   = 60,
  parameter int unsigned IX       = 480,
  parameter int unsigned IY       = 240,
  parameter int unsigned SPACING  = 240,
  parameter int unsigned Y_MIN    = 100,
  parameter int unsigned Y_MAX    = 380,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int unsigned D_WIDTH  = 640,
  parameter int unsigned D_HEIGHT = 480
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_physics_stb,
  input  logic                   i_start,
  input  logic                   i_crash,
  input  logic [3:0]             i_speed,
  input  logic [11:0]            i_bird_x,
  output logic [12*N_PIPES-1:0]  o_x1,
  output logic [12*N_PIPES-1:0]  o_x2,
  output logic [12*N_PIPES-1:0]  o_y1,
  output logic [12*N_PIPES-1:0]  o_y2,
  output logic [1:0]             o_state,
  output logic                   o_pass,
  output logic [7:0]             o_score
);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StHalt = 2'd2} state_e;

  localparam logic [11:0] XSize  = 12'(X_SIZE);
  localparam logic [11:0] YHole  = 12'(Y_HOLE);
  localparam logic [11:0] YMin   = 12'(Y_MIN);
  localparam logic [11:0] YRange = 12'(Y_MAX - Y_MIN);
  localparam logic [11:0] Wrap   = 12'(N_PIPES * SPACING);

  // Elaboration-time guard against parameter sets that break spacing or hole placement.
  if (N_PIPES < 1 || N_PIPES > 8 || N_PIPES * SPACING < D_WIDTH + X_SIZE ||
      Y_MAX <= Y_MIN || Y_MAX - Y_MIN < 256 || Y_MAX - Y_MIN > 511 ||
      Y_MAX > D_HEIGHT || SEED == 16'd0) begin : g_bad_params
    $error("pipe_field: invalid parameter set");
  end

  state_e      state_q, state_d;
  logic [11:0] x_q [N_PIPES];
  logic [11:0] x_d [N_PIPES];
  logic [11:0] y_q [N_PIPES];
  logic [11:0] y_d [N_PIPES];
  logic [15:0] lfsr_q, lfsr_d;
  logic        pass_q, pass_d;
  logic [7:0]  score_q, score_d;

  logic [11:0] step;
  logic [11:0] fold;
  logic [11:0] spawn_y;
  logic        any_pass;

  assign step    = {8'd0, i_speed};
  assign fold    = {3'd0, lfsr_q[8:0]};
  // Single conditional subtract folds the 9-bit LFSR value into [0, YRange).
  assign spawn_y = YMin + ((fold >= YRange) ? fold - YRange : fold);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < N_PIPES; k++) begin
        x_q[k] <= 12'(IX + k * SPACING);
        y_q[k] <= 12'(IY);
      end
      lfsr_q  <= SEED;
      state_q <= StIdle;
      pass_q  <= 1'b0;
      score_q <= 8'd0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      pass_q  <= pass_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    lfsr_d   = lfsr_q;
    pass_d   = 1'b0;
    score_d  = score_q;
    any_pass = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_start) state_d = StRun;
      end
      StRun: begin
        if (i_physics_stb) begin
          for (int unsigned k = 0; k < N_PIPES; k++) begin
            if (x_q[k] > step) begin
              x_d[k] = x_q[k] - step;
              if ((x_q[k] + XSize) >= i_bird_x && (x_q[k] - step + XSize) < i_bird_x) begin
                any_pass = 1'b1;
              end
            end else begin
              // Wrap by the full ring length so inter-pipe spacing is preserved exactly.
              x_d[k] = x_q[k] - step + Wrap;
              y_d[k] = spawn_y;
            end
          end
          lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        pass_d = any_pass;
        if (any_pass && score_q != 8'hFF) score_d = score_q + 8'd1;
        if (i_crash) state_d = StHalt;
      end
      default: ;
    endcase
  end

  for (genvar k = 0; k < N_PIPES; k++) begin : g_edges
    assign o_x1[12*k +: 12] = (x_q[k] < XSize) ? 12'd0 : x_q[k] - XSize;
    assign o_x2[12*k +: 12] = x_q[k] + XSize;
    assign o_y1[12*k +: 12] = y_q[k] - YHole;
    assign o_y2[12*k +: 12] = y_q[k] + YHole;
  end

  assign o_state = state_q;
  assign o_pass  = pass_q & (state_q == StRun);
  assign o_score = score_q;

endmodule

// File: tb/tb_pipe_field.sv
// Scoreboard bench for pipe_field: a behavioural model predicts every cycle's outputs,
// which are queued at drive time and popped against the DUT after the clock edge.
module tb_pipe_field;

  localparam int NP = 3;

  logic                i_clk;
  logic                i_rst_n;
  logic                i_physics_stb;
  logic                i_start;
  logic                i_crash;
  logic [3:0]          i_speed;
  logic [11:0]         i_bird_x;
  logic [12*NP-1:0]    o_x1;
  logic [12*NP-1:0]    o_x2;
  logic [12*NP-1:0]    o_y1;
  logic [12*NP-1:0]    o_y2;
  logic [1:0]          o_state;
  logic                o_pass;
  logic [7:0]          o_score;

  pipe_field dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_physics_stb (i_physics_stb),
    .i_start       (i_start),
    .i_crash       (i_crash),
    .i_speed       (i_speed),
    .i_bird_x      (i_bird_x),
    .o_x1          (o_x1),
    .o_x2          (o_x2),
    .o_y1          (o_y1),
    .o_y2          (o_y2),
    .o_state       (o_state),
    .o_pass        (o_pass),
    .o_score       (o_score)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int bird    = 0;

  // Model state
  int          m_x [NP];
  int          m_y [NP];
  logic [15:0] m_lfsr;
  int          m_state;
  bit          m_pass;
  int          m_score;

  logic [154:0] sb [$];
  logic [154:0] e;
  wire  [154:0] obs = {o_x1, o_x2, o_y1, o_y2, o_state, o_pass, o_score};

  task automatic model_step(input bit rst_n, input bit stb, input bit start, input bit crash,
                            input int spd);
    bit any;
    int v;
    any = 0;
    if (!rst_n) begin
      for (int k = 0; k < NP; k++) begin
        m_x[k] = 480 + 240 * k;
        m_y[k] = 240;
      end
      m_lfsr = 16'hACE1; m_state = 0; m_pass = 0; m_score = 0;
    end else if (m_state == 0) begin
      m_pass = 0;
      if (start) m_state = 1;
    end else if (m_state == 1) begin
      if (stb) begin
        v = int'(m_lfsr & 16'h01FF);
        if (v >= 280) v = v - 280;
        for (int k = 0; k < NP; k++) begin
          if (m_x[k] > spd) begin
            if ((m_x[k] + 40) >= bird && (m_x[k] - spd + 40) < bird) any = 1;
            m_x[k] = m_x[k] - spd;
          end else begin
            m_x[k] = (m_x[k] - spd + 720 + 4096) % 4096;
            m_y[k] = 100 + v;
          end
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
      m_pass = any;
      if (any && m_score < 255) m_score++;
      if (crash) m_state = 2;
    end else begin
      m_pass = 0;
    end
  endtask

  function automatic logic [154:0] mk_exp();
    logic [12*NP-1:0] x1, x2, y1, y2;
    for (int k = 0; k < NP; k++) begin
      x1[12*k +: 12] = (m_x[k] < 40) ? 12'd0 : 12'(m_x[k] - 40);
      x2[12*k +: 12] = 12'(m_x[k] + 40);
      y1[12*k +: 12] = 12'(m_y[k] - 60);
      y2[12*k +: 12] = 12'(m_y[k] + 60);
    end
    return {x1, x2, y1, y2, 2'(m_state), (m_pass && m_state == 1), 8'(m_score)};
  endfunction

  task automatic tick(input bit rst_n, input bit stb, input bit start, input bit crash,
                      input int spd);
    i_rst_n = rst_n; i_physics_stb = stb; i_start = start; i_crash = crash;
    i_speed = 4'(spd); i_bird_x = 12'(bird);
    model_step(rst_n, stb, start, crash, spd);
    sb.push_back(mk_exp());
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    tick(0, 1, 1, 0, 7);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset: got %h exp %h", obs, e); end
    n_tests++;
    if ({o_x1[11:0], o_x2[11:0], o_y1[11:0], o_y2[11:0]} !== {12'd440, 12'd520, 12'd180, 12'd300})
    begin
      n_fail++;
      $display("FAIL reset_edges: got %0d %0d %0d %0d exp 440 520 180 300",
               o_x1[11:0], o_x2[11:0], o_y1[11:0], o_y2[11:0]);
    end
    n_tests++;
    if (o_state !== 2'd0 || o_score !== 8'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d/%0d exp 0/0", o_state, o_score);
    end
  endtask

  task automatic test_scroll();
    tick(1, 0, 1, 0, 7);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL start: got %h exp %h", obs, e); end
    tick(1, 1, 0, 0, 7);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL scroll1: got %h exp %h", obs, e); end
    n_tests++;
    if (o_x2 !== {12'd993, 12'd753, 12'd513}) begin
      n_fail++; $display("FAIL scroll1_x2: got %h exp 3e12f1201", o_x2);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 0, 0, 7);
      e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL scroll%0d: got %h exp %h", i + 2, obs, e); end
    end
    n_tests++;
    if (o_x2 !== {12'd958, 12'd718, 12'd478} || o_y1 !== {3{12'd180}}) begin
      n_fail++; $display("FAIL scroll6_pos: got x2 %h y1 %h", o_x2, o_y1);
    end
  endtask

  task automatic test_respawn();
    tick(1, 1, 0, 0, 6);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL align: got %h exp %h", obs, e); end
    for (int i = 0; i < 61; i++) begin
      tick(1, 1, 0, 0, 7);
      e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL approach%0d: got %h exp %h", i, obs, e); end
    end
    n_tests++;
    if (o_x2[11:0] !== 12'd45) begin
      n_fail++; $display("FAIL at_five: got x2 %0d exp 45", o_x2[11:0]);
    end
    tick(1, 1, 0, 0, 7);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL respawn: got %h exp %h", obs, e); end
    n_tests++;
    if (o_x2[11:0] !== 12'd758 || o_y1[11:0] + 12'd60 < 12'd100 || o_y1[11:0] + 12'd60 > 12'd379)
    begin
      n_fail++; $display("FAIL respawn_range: got x2 %0d y1 %0d", o_x2[11:0], o_y1[11:0]);
    end
  endtask

  task automatic test_pass();
    bird = 160;
    tick(1, 1, 0, 0, 1);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL pass_align: got %h exp %h", obs, e); end
    for (int i = 0; i < 16; i++) begin
      tick(1, 1, 0, 0, 7);
      e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL pass_pre%0d: got %h exp %h", i, obs, e); end
    end
    tick(1, 1, 0, 0, 7);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL pass_strobe: got %h exp %h", obs, e); end
    n_tests++;
    if (o_pass !== 1'b1 || o_score !== 8'd1 || o_x2[23:12] !== 12'd158) begin
      n_fail++;
      $display("FAIL pass_pulse: got pass %0b score %0d x2 %0d exp 1 1 158",
               o_pass, o_score, o_x2[23:12]);
    end
    tick(1, 0, 0, 0, 7);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL pass_after: got %h exp %h", obs, e); end
    n_tests++;
    if (o_pass !== 1'b0) begin n_fail++; $display("FAIL pass_width: got %0b exp 0", o_pass); end
  endtask

  task automatic test_saturate();
    int extra;
    int guard;
    extra = 0;
    guard = 0;
    while ((m_score < 255 || extra < 2) && guard < 8000) begin
      tick(1, 1, 0, 0, 15);
      guard++;
      e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL sat%0d: got %h exp %h", guard, obs, e); end
      if (m_score == 255 && m_pass) extra++;
    end
    n_tests++;
    if (guard >= 8000 || o_score !== 8'd255) begin
      n_fail++; $display("FAIL saturate: got score %0d after %0d strobes exp 255", o_score, guard);
    end
  endtask

  task automatic test_crash();
    tick(1, 1, 0, 1, 5);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL crash: got %h exp %h", obs, e); end
    n_tests++;
    if (o_state !== 2'd2) begin n_fail++; $display("FAIL crash_state: got %0d exp 2", o_state); end
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 1, i[0], 9);
      e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL halt%0d: got %h exp %h", i, obs, e); end
    end
  endtask

  task automatic test_reset_mid_run();
    tick(0, 0, 0, 0, 0);
    e = sb.pop_front();
    tick(1, 0, 1, 0, 0);
    e = sb.pop_front();
    tick(1, 1, 0, 0, 11);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL rerun: got %h exp %h", obs, e); end
    tick(0, 1, 1, 0, 11);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_run: got %h exp %h", obs, e); end
    n_tests++;
    if (o_x2 !== {12'd1000, 12'd760, 12'd520} || o_state !== 2'd0 || o_score !== 8'd0) begin
      n_fail++; $display("FAIL reset_run_vals: got x2 %h st %0d sc %0d", o_x2, o_state, o_score);
    end
  endtask

  task automatic test_speed_zero();
    tick(1, 0, 1, 0, 0);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 0, 0);
      e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL speed0_%0d: got %h exp %h", i, obs, e); end
    end
    n_tests++;
    if (o_x2 !== {12'd1000, 12'd760, 12'd520} || o_pass !== 1'b0) begin
      n_fail++; $display("FAIL speed0_static: got x2 %h pass %0b", o_x2, o_pass);
    end
    // LFSR advanced during the zero-speed strobes; the next respawn y exposes it.
    for (int i = 0; i < 32; i++) begin
      tick(1, 1, 0, 0, 15);
      e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL post_speed0_%0d: got %h exp %h", i, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_respawn();
    test_pass();
    test_saturate();
    test_crash();
    test_reset_mid_run();
    test_speed_zero();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_field.md
Name: pipe_field

Overview:
- Manages N_PIPES scrolling pipe obstacles for the flappy-bird playfield. It replaces the single hard-wired pipe.
- Hole centres are pseudo-random (LFSR), scroll speed is runtime-selectable, pipe spacing is exact, and a run/halt state machine is included.
- Detects a pipe passing the bird column, issues a one-cycle pass pulse and keeps a saturating score.
- Sits between the physics strobe generator and the collision/draw logic.

Parameters:
- N_PIPES, 3, number of pipes (1-8).
- X_SIZE, 40, pipe half width in pixels.
- Y_HOLE, 60, hole half height in pixels.
- IX, 480, reset centre x of pipe 0.
- IY, 240, reset hole centre y of every pipe.
- SPACING, 240, centre-to-centre x distance between consecutive pipes; N_PIPES*SPACING must be >= D_WIDTH+X_SIZE.
- Y_MIN, 100, lowest hole centre.
- Y_MAX, 380, exclusive upper bound of hole centre; 256 <= Y_MAX-Y_MIN <= 511.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- D_WIDTH, 640, display width.
- D_HEIGHT, 480, display height.

Ports:
- i_clk, in, 1, base clock.
- i_rst_n, in, 1, synchronous active-low reset.
- i_physics_stb, in, 1, one-cycle physics tick.
- i_start, in, 1, level; IDLE->RUN.
- i_crash, in, 1, level; RUN->HALT.
- i_speed, in, 4, pixels moved per physics tick; 0 = no motion.
- i_bird_x, in, 12, bird centre column.
- o_x1, out, 12*N_PIPES, left edges; pipe k in bits [12k+11:12k].
- o_x2, out, 12*N_PIPES, right edges.
- o_y1, out, 12*N_PIPES, hole top edges.
- o_y2, out, 12*N_PIPES, hole bottom edges.
- o_state, out, 2, 0=IDLE, 1=RUN, 2=HALT.
- o_pass, out, 1, one-cycle pulse when a pipe clears the bird.
- o_score, out, 8, pipes passed, saturating.

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - Pipe k: x_k=IX+k*SPACING, y_k=IY.
  - LFSR=SEED, state=IDLE, o_pass=0, o_score=0.
  - Reset has priority over every other input in the same cycle.
- Edges are combinational from registers:
  - x1=(x<X_SIZE)?0:x-X_SIZE.
  - x2=x+X_SIZE.
  - y1=y-Y_HOLE.
  - y2=y+Y_HOLE.
  - All arithmetic is 12-bit.
- FSM:
  - IDLE: pipes static; i_start=1 -> RUN next cycle.
  - RUN: motion enabled; i_crash=1 -> HALT next cycle, and any strobe that cycle is still applied.
  - HALT: pipes frozen; i_start and i_crash are ignored; exits only via reset.
- Motion occurs only in RUN on a cycle with i_physics_stb=1. Let s=i_speed sampled that cycle. For each pipe:
  - If x > s: x <= x-s.
  - Else (respawn): x <= x-s+N_PIPES*SPACING, computed modulo 4096 then wrapping back positive; this preserves spacing exactly. y <= Y_MIN+f, where v=LFSR[8:0] and f=(v>=Y_MAX-Y_MIN)?v-(Y_MAX-Y_MIN):v.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11 (feedback=b15^b13^b12^b10 shifted into b0).
  - Advances once per RUN physics strobe, after its current value is used for any respawn.
  - All pipes respawning on the same strobe receive the same y.
- Pass detection, per RUN strobe per pipe:
  - Condition: old x2 >= i_bird_x and new x2 < i_bird_x, excluding respawning pipes.
  - Result: o_pass=1 on the next cycle only; o_score increments by 1 per strobe with at least one pass; o_score saturates at 255.
- o_pass is 0 in IDLE and HALT. The score holds in HALT.
- i_speed=0 during RUN strobes: nothing moves, no respawn, no pass; the LFSR still advances.
- Strobes in IDLE or HALT change no pipe, LFSR or score state.

Test Plan:
- Reset, N_PIPES=3, defaults -> centres 480/720/960, y=240. o_x1[11:0]=440, o_x2[11:0]=520, o_y1=180, o_y2=300. o_state=0, o_score=0.
- i_start, speed 7, one strobe -> x=473/713/953. Five more strobes -> x=438/678/918. y unchanged.
- Pipe 0 at x=5, speed 7, strobe -> x0=718, y0=Y_MIN+fold(LFSR[8:0]) matches bench LFSR model and lies in [100,379]. Next LFSR value matches model.
- i_bird_x=160, pipe x=125->118 at speed 7 (x2 165->158) -> o_pass high exactly one cycle after strobe, o_score=1. Score forced to 255 plus another pass -> stays 255.
- RUN with i_crash=1 and strobe in the same cycle -> that move applied, o_state=2. Further strobes and i_start -> no change.
- i_rst_n=0 with i_physics_stb=1 mid-RUN -> reset values only. Speed 0 strobes in RUN -> positions static, o_pass=0.
